// File: rtl/magma_slave_arb.sv
// Round-robin arbiter sharing one slave among NUM_M masters; read owners are queued to route each resp back.
// Request, ack and resp paths are combinational (0 cycles); new requests stall while RESP_DEPTH reads are outstanding.
module magma_slave_arb #(
  parameter int NUM_M      = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [NUM_M-1:0]      m_req_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [32*NUM_M-1:0]   m_addr_bi,
  input  logic [4*NUM_M-1:0]    m_be_i,
  input  logic [32*NUM_M-1:0]   m_wdata_bi,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_resp_o,
  output logic [32*NUM_M-1:0]   m_rdata_bo,
  output logic                  s_req_o,
  output logic                  s_we_o,
  output logic [31:0]           s_addr_bo,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_wdata_bo,
  input  logic                  s_ack_i,
  input  logic                  s_resp_i,
  input  logic [31:0]           s_rdata_bi,
  output logic                  err_o
);

  localparam int IDW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int PW  = $clog2(RESP_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RESP_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_q, gnt_d, rr_ptr, rr_d;
  logic [IDW-1:0] winner, fwd_id;
  logic           win_vld, fwd_vld, blocked, ack_fire, push, pop;

  logic [IDW-1:0] fifo_mem [RESP_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (int'(id) == NUM_M - 1) ? '0 : id + 1'b1;
  endfunction

  assign blocked = (count == FULL);

  // Scan backwards so the lowest offset from rr_ptr is the last to write winner.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    win_vld = 1'b0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_M;
      if (m_req_i[idx]) begin
        winner  = IDW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_ptr;
    fwd_id  = '0;
    fwd_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld && !blocked) begin
          fwd_id  = winner;
          fwd_vld = 1'b1;
          if (s_ack_i) begin
            rr_d = next_id(winner);
          end else begin
            gnt_d   = winner;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        fwd_id = gnt_q;
        if (m_req_i[gnt_q] && !blocked) begin
          fwd_vld = 1'b1;
          if (s_ack_i) begin
            rr_d    = next_id(gnt_q);
            state_d = IDLE;
          end
        end else begin
          // Owner withdrew its request: release the lock without advancing rr_ptr.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_ptr  <= rr_d;
    end
  end

  // Strobes are masked during reset so the port is quiet the moment reset asserts.
  assign s_req_o    = fwd_vld & ~arst_i;
  assign s_we_o     = m_we_i[fwd_id];
  assign s_addr_bo  = m_addr_bi[32*int'(fwd_id) +: 32];
  assign s_be_o     = m_be_i[4*int'(fwd_id) +: 4];
  assign s_wdata_bo = m_wdata_bi[32*int'(fwd_id) +: 32];
  assign m_rdata_bo = {NUM_M{s_rdata_bi}};

  assign ack_fire = s_req_o & s_ack_i;
  assign push     = ack_fire & ~s_we_o;
  assign pop      = s_resp_i & (count != '0) & ~arst_i;

  always_comb begin
    m_ack_o                   = '0;
    m_ack_o[fwd_id]           = ack_fire;
    m_resp_o                  = '0;
    m_resp_o[fifo_mem[rd_ptr]] = pop;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= fwd_id;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_resp_i && count == '0) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_magma_slave_arb.sv
// Directed bench for magma_slave_arb: round-robin order, lock hold, FIFO-full stall, stray resp, mid-transfer reset.
module tb_magma_slave_arb;

  logic          clk;
  logic          arst;
  logic [3:0]    m_req, m_we, m_ack, m_resp;
  logic [127:0]  m_addr, m_wdata, m_rdata;
  logic [15:0]   m_be;
  logic          s_req, s_we, s_ack, s_resp, err;
  logic [31:0]   s_addr, s_wdata, s_rdata;
  logic [3:0]    s_be;

  int n_cmp = 0;
  int n_bad = 0;

  magma_slave_arb #(.NUM_M(4), .RESP_DEPTH(4)) dut (
    .clk_i(clk), .arst_i(arst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_bi(m_addr), .m_be_i(m_be), .m_wdata_bi(m_wdata),
    .m_ack_o(m_ack), .m_resp_o(m_resp), .m_rdata_bo(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_o(s_be), .s_wdata_bo(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    idle_inputs();
    cyc();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    idle_inputs();
    m_addr[31:0] = 32'hA0; m_addr[63:32] = 32'hB1;
    #2;
    n_cmp++; if (s_req !== 1'b0)  begin n_bad++; $display("FAIL rst_s_req got %b exp 0", s_req); end
    n_cmp++; if (m_ack !== 4'h0)  begin n_bad++; $display("FAIL rst_m_ack got %b exp 0000", m_ack); end
    n_cmp++; if (m_resp !== 4'h0) begin n_bad++; $display("FAIL rst_m_resp got %b exp 0000", m_resp); end
    n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL rst_err got %b exp 0", err); end
    n_cmp++; if (s_addr !== 32'hA0) begin n_bad++; $display("FAIL rst_s_addr got %h exp 000000a0", s_addr); end
    cyc();
    arst = 1'b0;
    #2;
    n_cmp++; if (s_req !== 1'b0)  begin n_bad++; $display("FAIL idle_s_req got %b exp 0", s_req); end
    cyc();
  endtask

  task automatic test_rr_reads();
    logic [3:0] exp_ack, exp_resp;
    int win, prev;
    do_reset();
    for (int k = 0; k < 4; k++) m_addr[32*k +: 32] = 32'h1000 + k;
    m_req = 4'b0101; m_we = 4'b0000; s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      win      = (i % 2 == 0) ? 0 : 2;
      prev     = (i % 2 == 0) ? 2 : 0;
      exp_ack  = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_resp = (i == 0) ? 4'b0000 : ((i % 2 == 1) ? 4'b0001 : 4'b0100);
      s_resp   = (i > 0);
      s_rdata  = 32'h100 + prev;
      #2;
      n_cmp++; if (m_ack !== exp_ack) begin n_bad++; $display("FAIL rr_ack[%0d] got %b exp %b", i, m_ack, exp_ack); end
      n_cmp++; if (s_addr !== 32'h1000 + win) begin n_bad++; $display("FAIL rr_addr[%0d] got %h exp %h", i, s_addr, 32'h1000 + win); end
      n_cmp++; if (m_resp !== exp_resp) begin n_bad++; $display("FAIL rr_resp[%0d] got %b exp %b", i, m_resp, exp_resp); end
      if (i > 0) begin
        n_cmp++; if (m_rdata[32*prev +: 32] !== 32'h100 + prev)
          begin n_bad++; $display("FAIL rr_rdata[%0d] got %h exp %h", i, m_rdata[32*prev +: 32], 32'h100 + prev); end
      end
      cyc();
    end
    m_req = '0; s_ack = 1'b0; s_resp = 1'b1; s_rdata = 32'h102;
    #2;
    n_cmp++; if (m_resp !== 4'b0100) begin n_bad++; $display("FAIL rr_last_resp got %b exp 0100", m_resp); end
    n_cmp++; if (m_rdata[95:64] !== 32'h102) begin n_bad++; $display("FAIL rr_last_rdata got %h exp 00000102", m_rdata[95:64]); end
    cyc();
    s_resp = 1'b0;
    #2;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rr_err got %b exp 0", err); end
    cyc();
  endtask

  task automatic test_lock();
    do_reset();
    m_addr[63:32] = 32'h40; m_be[7:4] = 4'hF; m_wdata[63:32] = 32'hDEADBEEF;
    m_addr[127:96] = 32'h3000; m_be[15:12] = 4'h3;
    m_req = 4'b1010; m_we = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      s_ack = (c == 4);
      #2;
      n_cmp++; if (s_req !== 1'b1) begin n_bad++; $display("FAIL lock_s_req[%0d] got %b exp 1", c, s_req); end
      n_cmp++; if (s_addr !== 32'h40) begin n_bad++; $display("FAIL lock_addr[%0d] got %h exp 00000040", c, s_addr); end
      n_cmp++; if ({s_we, s_be} !== 5'b11111) begin n_bad++; $display("FAIL lock_we_be[%0d] got %b exp 11111", c, {s_we, s_be}); end
      n_cmp++; if (s_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lock_wdata[%0d] got %h exp deadbeef", c, s_wdata); end
      n_cmp++; if (m_ack !== ((c == 4) ? 4'b0010 : 4'b0000))
        begin n_bad++; $display("FAIL lock_ack[%0d] got %b exp %b", c, m_ack, (c == 4) ? 4'b0010 : 4'b0000); end
      cyc();
    end
    m_req = 4'b1000; s_ack = 1'b0;
    #2;
    n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h3000 || s_we !== 1'b0)
      begin n_bad++; $display("FAIL lock_next got req=%b addr=%h we=%b exp req=1 addr=00003000 we=0", s_req, s_addr, s_we); end
    cyc();
    s_ack = 1'b1;
    #2;
    n_cmp++; if (m_ack !== 4'b1000) begin n_bad++; $display("FAIL lock_m3_ack got %b exp 1000", m_ack); end
    cyc();
    m_req = '0; s_ack = 1'b0; s_resp = 1'b1;
    #2;
    n_cmp++; if (m_resp !== 4'b1000) begin n_bad++; $display("FAIL lock_m3_resp got %b exp 1000", m_resp); end
    cyc();
    s_resp = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    m_addr[31:0] = 32'h500; m_req = 4'b0001; m_we = '0; s_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      n_cmp++; if (s_req !== (c < 4)) begin n_bad++; $display("FAIL full_s_req[%0d] got %b exp %b", c, s_req, (c < 4)); end
      n_cmp++; if (m_ack !== ((c < 4) ? 4'b0001 : 4'b0000))
        begin n_bad++; $display("FAIL full_ack[%0d] got %b exp %b", c, m_ack, (c < 4) ? 4'b0001 : 4'b0000); end
      cyc();
    end
    s_resp = 1'b1; s_rdata = 32'h77;
    #2;
    n_cmp++; if (m_resp !== 4'b0001) begin n_bad++; $display("FAIL full_pop_resp got %b exp 0001", m_resp); end
    n_cmp++; if (s_req !== 1'b0 || m_ack !== 4'b0000)
      begin n_bad++; $display("FAIL full_pop_block got req=%b ack=%b exp req=0 ack=0000", s_req, m_ack); end
    cyc();
    s_resp = 1'b0;
    #2;
    n_cmp++; if (s_req !== 1'b1 || m_ack !== 4'b0001)
      begin n_bad++; $display("FAIL full_refill got req=%b ack=%b exp req=1 ack=0001", s_req, m_ack); end
    cyc();
    #2;
    n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL full_again got %b exp 0", s_req); end
    cyc();
    m_req = '0; s_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_resp = 1'b1;
      #2;
      n_cmp++; if (m_resp !== 4'b0001) begin n_bad++; $display("FAIL full_drain[%0d] got %b exp 0001", c, m_resp); end
      cyc();
    end
    s_resp = 1'b0;
    #2;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err got %b exp 0", err); end
    cyc();
  endtask

  task automatic test_err();
    do_reset();
    s_resp = 1'b1;
    #2;
    n_cmp++; if (m_resp !== 4'b0000) begin n_bad++; $display("FAIL err_resp got %b exp 0000", m_resp); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_early got %b exp 0", err); end
    cyc();
    s_resp = 1'b0;
    #2;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b exp 1", err); end
    repeat (3) cyc();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_hold got %b exp 1", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_addr[31:0] = 32'h500; m_addr[63:32] = 32'h40; m_addr[95:64] = 32'h2000;
    m_req = 4'b0100; m_we = '0; s_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_cmp++; if (m_ack !== 4'b0100) begin n_bad++; $display("FAIL mid_rd_ack[%0d] got %b exp 0100", c, m_ack); end
      cyc();
    end
    m_req = 4'b0010; m_we = 4'b0010; s_ack = 1'b0;
    #2;
    n_cmp++; if (s_addr !== 32'h40) begin n_bad++; $display("FAIL mid_lock_addr got %h exp 00000040", s_addr); end
    cyc();
    m_req = 4'b0011;
    #2;
    n_cmp++; if (s_addr !== 32'h40) begin n_bad++; $display("FAIL mid_locked_addr got %h exp 00000040", s_addr); end
    #1;
    arst = 1'b1; s_ack = 1'b1; s_resp = 1'b1;
    #1;
    n_cmp++; if ({s_req, m_ack, m_resp, err} !== 10'b0)
      begin n_bad++; $display("FAIL mid_rst_quiet got req=%b ack=%b resp=%b err=%b exp all 0", s_req, m_ack, m_resp, err); end
    cyc();
    s_ack = 1'b0; s_resp = 1'b0; m_we = '0; arst = 1'b0;
    #2;
    n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h500)
      begin n_bad++; $display("FAIL mid_first_win got req=%b addr=%h exp req=1 addr=00000500", s_req, s_addr); end
    cyc();
    m_req = '0; s_resp = 1'b1;
    #2;
    n_cmp++; if (m_resp !== 4'b0000) begin n_bad++; $display("FAIL mid_flushed_resp got %b exp 0000", m_resp); end
    cyc();
    s_resp = 1'b0;
    #2;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mid_err got %b exp 1", err); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_rr_reads();
    test_lock();
    test_full();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
